// File: rtl/cpu_pkg.sv
// Shared datapath definitions for the CPU register file.
//   DATA_W   - register and data-port width
//   ADDR_W   - register address width
//   DEPTH    - number of architectural registers (2**ADDR_W)
//   REG_ZERO - address of the hardwired zero register
//   word_t   - one DATA_W-wide register value
package cpu_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 2 ** ADDR_W;

    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef logic [DATA_W-1:0] word_t;
endpackage

// File: rtl/reg_files_if.sv
// Register-file access bus: one write port and two read ports.
//   we             - write enable, active high
//   waddr, wdata   - write address / data (committed on the falling clock edge)
//   raddr1, raddr2 - read addresses
//   rdata1, rdata2 - combinational read data
// master drives addresses/write data; slave (the register file) drives read data.
interface reg_files_if;
    import cpu_pkg::*;

    logic              we;
    logic [ADDR_W-1:0] waddr;
    word_t             wdata;
    logic [ADDR_W-1:0] raddr1;
    logic [ADDR_W-1:0] raddr2;
    word_t             rdata1;
    word_t             rdata2;

    modport master (
        output we, waddr, wdata, raddr1, raddr2,
        input  rdata1, rdata2
    );

    modport slave (
        input  we, waddr, wdata, raddr1, raddr2,
        output rdata1, rdata2
    );
endinterface

// File: rtl/reg_cell.sv
// One register of the file: a DATA_W flop with load enable, clocked on the
// falling edge so a write lands mid-cycle, with asynchronous active-low clear.
//   clk - clock (falling edge active)
//   rst - asynchronous clear, active low; dominates the load enable
//   en  - load enable
//   d   - load data
//   q   - stored value
module reg_cell
    import cpu_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  en,
    input  word_t d,
    output word_t q
);

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/reg_files.sv
// 32 x 32-bit general-purpose register file for the single-cycle datapath.
// Two combinational read ports, one write port committed on the falling clock
// edge, register 0 hardwired to zero.
//   clk - clock; writes commit on its falling edge
//   rst - asynchronous active-low reset, clears every register
//   bus - reg_files_if slave: we/waddr/wdata, raddr1/raddr2 in; rdata1/rdata2 out
module reg_files
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    reg_files_if.slave  bus
);

    word_t regs [DEPTH];

    // Register 0 has no storage; its mux input is a constant zero.
    assign regs[0] = '0;

    // Each cell compares the write address against its own index, which
    // together form the one-hot write decoder.
    for (genvar i = 1; i < DEPTH; i++) begin : g_cell
        reg_cell u_cell (
            .clk (clk),
            .rst (rst),
            .en  (bus.we && (bus.waddr == ADDR_W'(i))),
            .d   (bus.wdata),
            .q   (regs[i])
        );
    end

    // No bypass of wdata: a same-address read sees the new value only once
    // the falling edge has committed it.
    assign bus.rdata1 = (bus.raddr1 == REG_ZERO) ? '0 : regs[bus.raddr1];
    assign bus.rdata2 = (bus.raddr2 == REG_ZERO) ? '0 : regs[bus.raddr2];

endmodule

// File: tb/tb_reg_files.sv
module tb_reg_files;
    import cpu_pkg::*;

    logic clk;
    logic rst;

    reg_files_if bus ();

    reg_files dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string tag;
        word_t e1;
        word_t e2;
    } exp_t;

    exp_t  sb[$];
    word_t model [DEPTH];
    int    total = 0;
    int    bad   = 0;

    function automatic word_t model_rd(input logic [ADDR_W-1:0] a);
        return (a == REG_ZERO) ? '0 : model[a];
    endfunction

    task automatic expect_rd(input string tag, input word_t e1, input word_t e2);
        exp_t x;
        x.tag = tag;
        x.e1  = e1;
        x.e2  = e2;
        sb.push_back(x);
    endtask

    task automatic check_rd();
        exp_t x;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL scoreboard_empty got=%0d entries exp=1", sb.size());
        end else begin
            x = sb.pop_front();
            total++;
            assert (bus.rdata1 === x.e1) else begin
                bad++;
                $error("FAIL %s rdata1 got=%h exp=%h", x.tag, bus.rdata1, x.e1);
            end
            total++;
            assert (bus.rdata2 === x.e2) else begin
                bad++;
                $error("FAIL %s rdata2 got=%h exp=%h", x.tag, bus.rdata2, x.e2);
            end
        end
    endtask

    // Set both read addresses, queue the expectation, then sample.
    task automatic read_chk(input string tag, input logic [ADDR_W-1:0] a1,
                            input logic [ADDR_W-1:0] a2,
                            input word_t e1, input word_t e2);
        bus.raddr1 = a1;
        bus.raddr2 = a2;
        expect_rd(tag, e1, e2);
        #1;
        check_rd();
    endtask

    // Drive a write during the high phase; it commits on the next falling edge.
    task automatic write_reg(input logic [ADDR_W-1:0] a, input word_t d);
        @(posedge clk);
        #1;
        bus.we    = 1'b1;
        bus.waddr = a;
        bus.wdata = d;
        @(negedge clk);
        if (rst && a != REG_ZERO) model[a] = d;
        #1;
        bus.we = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        rst        = 1'b0;
        bus.we     = 1'b0;
        bus.waddr  = '0;
        bus.wdata  = '0;
        bus.raddr1 = '0;
        bus.raddr2 = '0;
        #12;
        rst = 1'b1;

        // Reset state
        read_chk("reset_state", 5'd1, 5'd31, 32'h0, 32'h0);

        // Async reset mid-cycle
        write_reg(5'd5, 32'hDEADBEEF);
        read_chk("preload_r5", 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF);
        @(posedge clk);
        #2;
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        read_chk("async_reset", 5'd5, 5'd5, 32'h0, 32'h0);

        // Writes ignored while in reset
        bus.we    = 1'b1;
        bus.waddr = 5'd5;
        bus.wdata = 32'hCAFEF00D;
        @(negedge clk);
        #1;
        bus.we = 1'b0;
        read_chk("write_in_reset", 5'd5, 5'd5, 32'h0, 32'h0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        read_chk("reset_release", 5'd5, 5'd0, 32'h0, 32'h0);

        // Basic write/read
        write_reg(5'd3, 32'h01234567);
        read_chk("basic_wr", 5'd3, 5'd4, 32'h01234567, 32'h0);

        // Write disabled
        @(posedge clk);
        #1;
        bus.we    = 1'b0;
        bus.waddr = 5'd3;
        bus.wdata = 32'hFFFFFFFF;
        @(negedge clk);
        #1;
        read_chk("we_low", 5'd3, 5'd3, 32'h01234567, 32'h01234567);

        // Register 0 write discarded
        write_reg(5'd0, 32'h01234567);
        read_chk("r0_write", 5'd0, 5'd3, 32'h0, 32'h01234567);

        // Read-during-write timing
        write_reg(5'd7, 32'h11111111);
        @(posedge clk);
        #1;
        bus.we    = 1'b1;
        bus.waddr = 5'd7;
        bus.wdata = 32'h22222222;
        read_chk("rdw_old", 5'd7, 5'd7, 32'h11111111, 32'h11111111);
        @(negedge clk);
        model[7] = 32'h22222222;
        #1;
        bus.we = 1'b0;
        read_chk("rdw_new", 5'd7, 5'd7, 32'h22222222, 32'h22222222);

        // Full sweep
        for (int i = 1; i < DEPTH; i++) write_reg(ADDR_W'(i), 32'h01234567 + 32'(i));
        for (int i = 0; i < DEPTH; i++) begin
            read_chk($sformatf("sweep_%0d", i), ADDR_W'(i), ADDR_W'(DEPTH - 1 - i),
                     model_rd(ADDR_W'(i)), model_rd(ADDR_W'(DEPTH - 1 - i)));
        end

        // Reset after sweep clears everything
        #2;
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        for (int i = 0; i < DEPTH; i++) begin
            read_chk($sformatf("sweep_reset_%0d", i), ADDR_W'(i), ADDR_W'(DEPTH - 1 - i),
                     32'h0, 32'h0);
        end
        rst = 1'b1;

        total++;
        assert (sb.size() == 0) else begin
            bad++;
            $error("FAIL scoreboard_leftover got=%0d exp=0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
